// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the round-robin UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    localparam int DEFAULT_START_TIMEOUT = 4096;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Transmit-side handshake between the arbiter and a Uart8 transmitter.
interface uart_tx_arbiter_if;

    logic       txEn;
    logic       txStart;
    logic [7:0] txByte;
    logic       txBusy;
    logic       txDone;

    modport master (
        output txEn,
        output txStart,
        output txByte,
        input  txBusy,
        input  txDone
    );

    modport slave (
        input  txEn,
        input  txStart,
        input  txByte,
        output txBusy,
        output txDone
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping.
module rr_picker #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic                 found_o,
    output logic [IDX_WIDTH-1:0] idx_o
);

    int                 k;
    logic [NUM_REQ-1:0] shifted;

    // Scan farthest to nearest so the nearest set request is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        k       = 0;
        shifted = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            k       = (int'(ptr_i) + i) % NUM_REQ;
            shifted = req_i >> k;
            if (shifted[0]) begin
                found_o = 1'b1;
                idx_o   = IDX_WIDTH'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one Uart8 transmitter among NUM_REQ byte requesters, round-robin,
// with start-timeout and premature-busy-drop abort detection.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int IDX_WIDTH     = $clog2(NUM_REQ),
    parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   reqByte,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   errStrobe,
    output logic [IDX_WIDTH-1:0]   errIdx,
    output logic                   busy,
    output logic [IDX_WIDTH-1:0]   grantIdx,
    uart_tx_arbiter_if.master      tx
);

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    arb_state_e           state_q, state_d;
    logic [IDX_WIDTH-1:0] grant_q, grant_d;
    logic [IDX_WIDTH-1:0] rrPtr_q, rrPtr_d;
    logic [IDX_WIDTH-1:0] errIdx_q, errIdx_d;
    logic [7:0]           byte_q, byte_d;
    logic                 start_q, start_d;
    logic                 txEn_q, txEn_d;
    logic                 err_q, err_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 pick_found;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic [8*NUM_REQ-1:0] byte_shift;
    logic [7:0]           pick_byte;

    rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (rrPtr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign byte_shift = reqByte >> (8 * int'(pick_idx));
    assign pick_byte  = byte_shift[7:0];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rrPtr_d  = rrPtr_q;
        errIdx_d = errIdx_q;
        byte_d   = byte_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        ack_d    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (en && pick_found) begin
                    grant_d = pick_idx;
                    byte_d  = pick_byte;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (tx.txBusy) begin
                    start_d = 1'b0;
                    state_d = ST_BUSY;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    start_d  = 1'b0;
                    err_d    = 1'b1;
                    errIdx_d = grant_q;
                    rrPtr_d  = grant_q;
                    state_d  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // txDone has priority: Uart8 may drop txBusy in the same cycle.
                if (tx.txDone) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant_q == IDX_WIDTH'(i)) begin
                            ack_d[i] = 1'b1;
                        end
                    end
                    rrPtr_d = grant_q;
                    state_d = ST_IDLE;
                end else if (!tx.txBusy) begin
                    err_d    = 1'b1;
                    errIdx_d = grant_q;
                    rrPtr_d  = grant_q;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        txEn_d = en || (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rrPtr_q  <= IDX_WIDTH'(NUM_REQ - 1);
            errIdx_q <= '0;
            byte_q   <= '0;
            start_q  <= 1'b0;
            txEn_q   <= 1'b0;
            err_q    <= 1'b0;
            ack_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rrPtr_q  <= rrPtr_d;
            errIdx_q <= errIdx_d;
            byte_q   <= byte_d;
            start_q  <= start_d;
            txEn_q   <= txEn_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ack        = ack_q;
    assign errStrobe  = err_q;
    assign errIdx     = errIdx_q;
    assign busy       = (state_q != ST_IDLE);
    assign grantIdx   = grant_q;
    assign tx.txEn    = txEn_q;
    assign tx.txStart = start_q;
    assign tx.txByte  = byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the Uart8 handshake is driven by hand.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  req;
    logic [31:0] reqByte;
    logic [3:0]  ack;
    logic        errStrobe;
    logic [1:0]  errIdx;
    logic        busy;
    logic [1:0]  grantIdx;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_arbiter_if tx_if();

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .IDX_WIDTH     (2),
        .START_TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .reqByte   (reqByte),
        .ack       (ack),
        .errStrobe (errStrobe),
        .errIdx    (errIdx),
        .busy      (busy),
        .grantIdx  (grantIdx),
        .tx        (tx_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        en            = 1'b0;
        req           = '0;
        reqByte       = '0;
        tx_if.txBusy  = 1'b0;
        tx_if.txDone  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Called at the negedge where txStart should have just risen.
    task automatic serve(input int idx, input logic [7:0] b);
        chk("start_hi", tx_if.txStart, 1);
        chk("grant", grantIdx, idx);
        chk("tx_byte", tx_if.txByte, b);
        chk("busy_hi", busy, 1);
        tx_if.txBusy = 1'b1;
        tick();
        chk("start_drop", tx_if.txStart, 0);
        tick();
        tx_if.txDone = 1'b1;
        tx_if.txBusy = 1'b0;
        tick();
        chk("ack", ack, 32'(1) << idx);
        chk("err_none", errStrobe, 0);
        chk("busy_lo", busy, 0);
        tx_if.txDone = 1'b0;
    endtask

    initial begin
        int seen;
        int n;
        logic [7:0] rr_bytes [4];
        rr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset values
        do_reset();
        chk("rst_ack", ack, 0);
        chk("rst_err", errStrobe, 0);
        chk("rst_erridx", errIdx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grantIdx, 0);
        chk("rst_start", tx_if.txStart, 0);
        chk("rst_byte", tx_if.txByte, 0);
        chk("rst_txen", tx_if.txEn, 0);

        // Single requester
        en      = 1'b1;
        req     = 4'b0100;
        reqByte = 32'h008A_0000;
        tick();
        chk("single_txen", tx_if.txEn, 1);
        serve(2, 8'h8A);
        req = '0;
        tick();
        chk("single_ack_once", ack, 0);
        chk("single_idle", busy, 0);

        // Round-robin fairness
        do_reset();
        en      = 1'b1;
        req     = 4'b1111;
        reqByte = 32'h4433_2211;
        for (int i = 0; i < 6; i++) begin
            tick();
            serve(i % 4, rr_bytes[i % 4]);
        end
        req = '0;
        tick();

        // en gating
        do_reset();
        req     = 4'b0010;
        reqByte = 32'h0000_5A00;
        seen    = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (tx_if.txStart) seen++;
        end
        chk("gate_nostart", seen, 0);
        chk("gate_txen_lo", tx_if.txEn, 0);
        en = 1'b1;
        tick();
        chk("gate_start", tx_if.txStart, 1);
        chk("gate_grant", grantIdx, 1);
        tx_if.txBusy = 1'b1;
        tick();
        en = 1'b0;
        tick();
        chk("gate_txen_busy1", tx_if.txEn, 1);
        tick();
        chk("gate_txen_busy2", tx_if.txEn, 1);
        tx_if.txDone = 1'b1;
        tx_if.txBusy = 1'b0;
        tick();
        chk("gate_ack", ack, 4'b0010);
        chk("gate_txen_off", tx_if.txEn, 0);
        tx_if.txDone = 1'b0;
        req = '0;
        tick();

        // Start timeout (START_TIMEOUT = 16)
        do_reset();
        en      = 1'b1;
        req     = 4'b0011;
        reqByte = 32'h0000_B2A1;
        tick();
        chk("to_grant", grantIdx, 0);
        n = 0;
        while (tx_if.txStart && n < 100) begin
            n++;
            if (ack != 0) chk("to_no_ack_during", ack, 0);
            tick();
        end
        chk("to_len", n, 16);
        chk("to_err", errStrobe, 1);
        chk("to_erridx", errIdx, 0);
        chk("to_ack", ack, 0);
        tick();
        chk("to_err_pulse", errStrobe, 0);
        serve(1, 8'hB2);
        req = '0;
        tick();

        // Premature busy drop
        do_reset();
        en      = 1'b1;
        req     = 4'b1000;
        reqByte = 32'h5C00_0000;
        tick();
        chk("pb_grant", grantIdx, 3);
        chk("pb_byte", tx_if.txByte, 8'h5C);
        tx_if.txBusy = 1'b1;
        tick();
        tick();
        tx_if.txBusy = 1'b0;
        tick();
        chk("pb_err", errStrobe, 1);
        chk("pb_erridx", errIdx, 3);
        chk("pb_ack", ack, 0);
        chk("pb_busy", busy, 0);
        req = '0;
        tick();
        chk("pb_err_pulse", errStrobe, 0);

        // Stale txDone in IDLE and START is ignored
        tx_if.txDone = 1'b1;
        tick();
        chk("stale_idle_ack", ack, 0);
        req     = 4'b0001;
        reqByte = 32'h0000_0077;
        tick();
        chk("stale_start", tx_if.txStart, 1);
        tick();
        chk("stale_start_ack", ack, 0);
        chk("stale_start_busy", busy, 1);
        tx_if.txDone = 1'b0;
        tx_if.txBusy = 1'b1;
        tick();
        tx_if.txDone = 1'b1;
        tx_if.txBusy = 1'b0;
        tick();
        chk("stale_ack", ack, 4'b0001);
        tx_if.txDone = 1'b0;
        req = '0;
        tick();

        // Reset mid-frame
        req     = 4'b0100;
        reqByte = 32'h00C3_0000;
        tick();
        tx_if.txBusy = 1'b1;
        tick();
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        chk("mid_start", tx_if.txStart, 0);
        chk("mid_txen", tx_if.txEn, 0);
        chk("mid_busy_lo", busy, 0);
        chk("mid_grant", grantIdx, 0);
        chk("mid_byte", tx_if.txByte, 0);
        chk("mid_erridx", errIdx, 0);
        chk("mid_ack", ack, 0);
        chk("mid_err", errStrobe, 0);
        reset        = 1'b0;
        tx_if.txBusy = 1'b0;
        req          = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
